bus_sel_ctrl: RTL and testbench

BUS_SEL_CTRL -- requirements
Module: bus_sel_ctrl

---
 rtl/bus_sel_ctrl.sv | 155 +++++++++++++++
 tb/tb_bus_sel_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_sel_ctrl.sv
// -----------------------------------------------------------------------------
// bus_sel_ctrl
//   Arbitrates shared-bus drive requests from NUM_SRC sources. The lowest-index
//   requester wins. The grant is registered one cycle after src_en is sampled.
//   While hold is high, an active grant is frozen (LOCK state).
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   clr          : synchronous active-high reset
//   src_en       : per-source drive request, bit i = source i
//   hold         : freezes the current grant while high
//   grant        : registered one-hot grant (all zero when idle)
//   sel          : registered binary index of the granted source (0 when idle)
//   sel_valid    : high while a grant is active
//   conflict     : one-cycle pulse aligned with a grant decided from >1 request
//   conflict_cnt : saturating (255) count of conflict pulses
//
// Configuration
//   BUS_CONFLICT_CNT_EN : when defined, conflict_cnt is a live counter;
//                         otherwise it is tied to 0 and no counter is built.
// -----------------------------------------------------------------------------
module bus_sel_ctrl #(
    parameter int unsigned NUM_SRC = 24,
    parameter int unsigned SEL_W   = 5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_SRC-1:0] src_en,
    input  logic               hold,
    output logic [NUM_SRC-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               conflict,
    output logic [7:0]         conflict_cnt
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOCK  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 valid_q, valid_d;
    logic                 conflict_q, conflict_d;

    logic [NUM_SRC-1:0]   pick_oh;
    logic [SEL_W-1:0]     pick_idx;
    logic                 any_req;
    logic                 multi_req;

    // Lowest-index request wins: scan downwards so the last hit is the lowest.
    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (src_en[i]) begin
                pick_oh    = '0;
                pick_oh[i] = 1'b1;
                pick_idx   = SEL_W'(i);
            end
        end
    end

    assign any_req   = |src_en;
    // Clearing the lowest set bit leaves something only if >1 bit was set.
    assign multi_req = |(src_en & (src_en - {{(NUM_SRC-1){1'b0}}, 1'b1}));

    // State and output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!hold && any_req) state_d = DRIVE;
            end
            DRIVE: begin
                if (hold)          state_d = LOCK;
                else if (!any_req) state_d = IDLE;
            end
            LOCK: begin
                if (!hold) state_d = any_req ? DRIVE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next-values, keyed on the state being entered
    always_comb begin
        grant_d    = grant_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        conflict_d = 1'b0;
        case (state_d)
            IDLE: begin
                grant_d = '0;
                sel_d   = '0;
                valid_d = 1'b0;
            end
            DRIVE: begin
                grant_d = pick_oh;
                sel_d   = pick_idx;
                valid_d = 1'b1;
            end
            default: ; // LOCK keeps the frozen grant
        endcase
        // Only fresh decisions made outside LOCK can flag a conflict.
        if (state_q != LOCK && state_d == DRIVE && multi_req) conflict_d = 1'b1;
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign sel_valid = valid_q;
    assign conflict  = conflict_q;

`ifdef BUS_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count, stepped together with the conflict pulse register.
    always_comb begin
        cnt_d = cnt_q;
        if (conflict_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_bus_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_sel_ctrl
//   Directed self-checking bench for bus_sel_ctrl (NUM_SRC=24, SEL_W=5).
//   Inputs change 1 time unit after a rising edge; outputs are checked at the
//   same point after the edge that registers the decision.
// -----------------------------------------------------------------------------
module tb_bus_sel_ctrl;

    localparam int unsigned NUM_SRC = 24;
    localparam int unsigned SEL_W   = 5;
`ifdef BUS_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               clr;
    logic [NUM_SRC-1:0] src_en;
    logic               hold;
    logic [NUM_SRC-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               conflict;
    logic [7:0]         conflict_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_conf   = 0;   // conflict events issued so far

    bus_sel_ctrl #(.NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
        .clk          (clk),
        .clr          (clr),
        .src_en       (src_en),
        .hold         (hold),
        .grant        (grant),
        .sel          (sel),
        .sel_valid    (sel_valid),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt();
        if (!CNT_EN) return 32'd0;
        return (n_conf > 255) ? 32'd255 : 32'(n_conf);
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_grant"}, 32'(grant), 32'd0);
        check_eq({tag, "_sel"}, 32'(sel), 32'd0);
        check_eq({tag, "_valid"}, 32'(sel_valid), 32'd0);
    endtask

    task automatic check_grant(input string tag, input int idx);
        check_eq({tag, "_grant"}, 32'(grant), 32'd1 << idx);
        check_eq({tag, "_sel"}, 32'(sel), 32'(idx));
        check_eq({tag, "_valid"}, 32'(sel_valid), 32'd1);
    endtask

    initial begin
        // Reset while requests and hold are active
        clr = 1'b1; hold = 1'b1; src_en = 24'h00_0F0F;
        tick();
        check_idle("rst");
        check_eq("rst_conflict", 32'(conflict), 32'd0);
        check_eq("rst_cnt", 32'(conflict_cnt), 32'd0);
        clr = 1'b0; hold = 1'b0; src_en = '0;
        tick();
        check_idle("rst_idle");

        // Single request, then release
        src_en = 24'h00_0020;
        tick();
        check_grant("single5", 5);
        check_eq("single5_conflict", 32'(conflict), 32'd0);
        src_en = '0;
        tick();
        check_idle("release");

        // Two requests: lowest index wins, one-cycle conflict
        src_en = (24'd1 << 3) | (24'd1 << 17);
        tick();
        n_conf++;
        check_grant("conf3_17", 3);
        check_eq("conf3_17_conflict", 32'(conflict), 32'd1);
        check_eq("conf3_17_cnt", 32'(conflict_cnt), exp_cnt());
        src_en = '0;
        tick();
        check_eq("conf_pulse_end", 32'(conflict), 32'd0);
        check_eq("conf_cnt_hold", 32'(conflict_cnt), exp_cnt());

        // Lock on sel=7, requests change underneath
        src_en = 24'd1 << 7;
        tick();
        check_grant("drive7", 7);
        hold = 1'b1; src_en = 24'd1 << 12;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_grant("lock7", 7);
            check_eq("lock7_conflict", 32'(conflict), 32'd0);
        end
        src_en = 24'h00_3000;    // multiple requests while locked: no conflict
        tick();
        check_grant("lock7_multi", 7);
        check_eq("lock_multi_conflict", 32'(conflict), 32'd0);
        check_eq("lock_multi_cnt", 32'(conflict_cnt), exp_cnt());
        hold = 1'b0; src_en = 24'd1 << 12;
        tick();
        check_grant("unlock12", 12);

        // Sustained request stays stable
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant("stable12", 12);
        end

        // Hold in IDLE keeps the block idle
        src_en = '0;
        tick();
        check_idle("to_idle");
        hold = 1'b1; src_en = 24'd1 << 2;
        tick();
        check_idle("idle_hold");
        tick();
        check_idle("idle_hold2");
        hold = 1'b0;
        tick();
        check_grant("idle_release2", 2);

        // Top index, and conflict between the extreme sources
        src_en = 24'd1 << 23;
        tick();
        check_grant("top23", 23);
        check_eq("top23_conflict", 32'(conflict), 32'd0);
        src_en = 24'h80_0001;
        tick();
        n_conf++;
        check_grant("conf0_23", 0);
        check_eq("conf0_23_conflict", 32'(conflict), 32'd1);
        check_eq("conf0_23_cnt", 32'(conflict_cnt), exp_cnt());

        // Clear during LOCK with sel=9 wins over hold
        src_en = 24'd1 << 9;
        tick();
        check_grant("drive9", 9);
        hold = 1'b1;
        tick();
        check_grant("lock9", 9);
        clr = 1'b1; src_en = 24'h00_0018;
        tick();
        n_conf = 0;
        check_idle("clr_lock");
        check_eq("clr_lock_conflict", 32'(conflict), 32'd0);
        check_eq("clr_lock_cnt", 32'(conflict_cnt), 32'd0);
        clr = 1'b0; hold = 1'b0; src_en = 24'd1 << 4;
        tick();
        check_grant("post_clr4", 4);

        // 300 separate two-source conflicts: counter saturates
        for (int i = 0; i < 300; i++) begin
            src_en = 24'h00_0006;
            tick();
            n_conf++;
            src_en = '0;
            tick();
        end
        check_eq("sat_cnt", 32'(conflict_cnt), exp_cnt());
        src_en = 24'h00_0006;
        tick();
        n_conf++;
        check_grant("sat_extra", 1);
        check_eq("sat_extra_conflict", 32'(conflict), 32'd1);
        check_eq("sat_hold_cnt", 32'(conflict_cnt), exp_cnt());
        src_en = '0;
        tick();
        check_eq("sat_final_cnt", 32'(conflict_cnt), exp_cnt());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
